sound_dma_host: RTL and testbench

SOUND_DMA_HOST -- requirements
Module: sound_dma_host

---
 rtl/sound_dma_host_if.sv | 36 +++
 rtl/sound_dma_host.sv | 161 ++++++++++++++++
 tb/tb_sound_dma_host.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_dma_host_if.sv
// rtl/sound_dma_host_if.sv - bus bundle for the sound DMA host: config, device handshake, memory port.
interface sound_dma_host_if;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        dma_req8;
  logic        dma_req16;
  logic        dma_ack;
  logic [15:0] dma_readdata;
  logic [15:0] dma_writedata;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        tc8;
  logic        tc16;
  logic        mask8;
  logic        mask16;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, dma_req8, dma_req16, dma_writedata,
           mem_rdata, mem_ready,
    output dma_ack, dma_readdata, mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
           tc8, tc16, mask8, mask16
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, dma_req8, dma_req16, dma_writedata,
           mem_rdata, mem_ready,
    input  dma_ack, dma_readdata, mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
           tc8, tc16, mask8, mask16
  );
endinterface

// File: rtl/sound_dma_host.sv
// rtl/sound_dma_host.sv - two-channel (8/16-bit) single-transfer DMA host for a sound DSP.
module sound_dma_host (
  input  logic             clk,
  input  logic             rst,
  sound_dma_host_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, GRANT, MEM, ACK, GAP} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        dir_q, dir_d;
  logic [15:0] base_addr_q [2];
  logic [15:0] cur_addr_q  [2];
  logic [15:0] base_cnt_q  [2];
  logic [15:0] cur_cnt_q   [2];
  logic [7:0]  page_q      [2];
  logic        dir_cfg_q   [2];
  logic        auto_q      [2];
  logic        mask_q      [2];
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cfg_valid, cfg_ch;
  logic [1:0]  cfg_reg;
  logic [2:0]  cfg_off;
  logic        ack_now, tc_now, elig8, elig16;
  logic        cfg_unused;

  assign cfg_unused = &{1'b0, bus.cfg_wdata[15:11]};

  always_comb begin
    cfg_valid = bus.cfg_we && (bus.cfg_addr <= 3'd5);
    cfg_ch    = bus.cfg_addr >= 3'd3;
    cfg_off   = cfg_ch ? bus.cfg_addr - 3'd3 : bus.cfg_addr;
    cfg_reg   = cfg_off[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    elig8   = bus.dma_req8 && !mask_q[0];
    elig16  = bus.dma_req16 && !mask_q[1];
    case (state_q)
      IDLE: if (elig8 || elig16) begin
        state_d = GRANT;
        sel_d   = !elig8;
        dir_d   = dir_cfg_q[!elig8];
      end
      GRANT:   state_d = MEM;
      MEM:     if (bus.mem_ready) state_d = ACK;
      ACK:     state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  assign ack_now          = state_q == ACK;
  assign tc_now           = ack_now && (cur_cnt_q[sel_q] == 16'd0);
  assign bus.dma_ack      = ack_now;
  assign bus.mem_rd       = (state_q == MEM) && !dir_q;
  assign bus.mem_wr       = (state_q == MEM) && dir_q;
  assign bus.tc8          = tc_now && !sel_q;
  assign bus.tc16         = tc_now && sel_q;
  assign bus.mask8        = mask_q[0];
  assign bus.mask16       = mask_q[1];
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.dma_readdata = rdata_q;

  // ch8 is byte-addressed within a 64K page; ch16 is word-addressed within a 128K page.
  always_comb begin
    if (!sel_q) begin
      mem_addr_d  = {page_q[0], cur_addr_q[0]};
      mem_be_d    = cur_addr_q[0][0] ? 2'b10 : 2'b01;
      mem_wdata_d = {bus.dma_writedata[7:0], bus.dma_writedata[7:0]};
      rdata_d     = {8'h00, mem_addr_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0]};
    end else begin
      mem_addr_d  = {page_q[1][7:1], cur_addr_q[1], 1'b0};
      mem_be_d    = 2'b11;
      mem_wdata_d = bus.dma_writedata;
      rdata_d     = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == GRANT) begin
        mem_addr_q <= mem_addr_d;
        mem_be_q   <= mem_be_d;
        if (dir_q) mem_wdata_q <= mem_wdata_d;
      end
      if (state_q == MEM && bus.mem_ready && !dir_q) rdata_q <= rdata_d;
    end
  end

  // The cfg write is issued after the ACK update so it overrides it on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        base_addr_q[c] <= '0;
        cur_addr_q[c]  <= '0;
        base_cnt_q[c]  <= '0;
        cur_cnt_q[c]   <= '0;
        page_q[c]      <= '0;
        dir_cfg_q[c]   <= 1'b0;
        auto_q[c]      <= 1'b0;
        mask_q[c]      <= 1'b1;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ack_now && sel_q == c[0]) begin
          if (tc_now && auto_q[c]) begin
            cur_addr_q[c] <= base_addr_q[c];
            cur_cnt_q[c]  <= base_cnt_q[c];
          end else begin
            cur_addr_q[c] <= cur_addr_q[c] + 16'd1;
            cur_cnt_q[c]  <= cur_cnt_q[c] - 16'd1;
            if (tc_now) mask_q[c] <= 1'b1;
          end
        end
        if (cfg_valid && cfg_ch == c[0]) begin
          case (cfg_reg)
            2'd0: begin
              base_addr_q[c] <= bus.cfg_wdata;
              cur_addr_q[c]  <= bus.cfg_wdata;
            end
            2'd1: begin
              base_cnt_q[c] <= bus.cfg_wdata;
              cur_cnt_q[c]  <= bus.cfg_wdata;
            end
            default: begin
              page_q[c]    <= bus.cfg_wdata[7:0];
              dir_cfg_q[c] <= bus.cfg_wdata[8];
              auto_q[c]    <= bus.cfg_wdata[9];
              mask_q[c]    <= bus.cfg_wdata[10];
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sound_dma_host.sv
// tb/tb_sound_dma_host.sv - directed, table-driven bench for sound_dma_host.
module tb_sound_dma_host;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sound_dma_host_if bus ();
  sound_dma_host dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        ch;
    logic [7:0]  page;
    logic [15:0] addr;
    logic [15:0] cnt;
    logic        dir;
    logic [15:0] rdata;
    logic [15:0] wdata;
    logic [23:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_data;
    logic        e_tc;
    logic        e_mask;
  } vec_t;

  vec_t        tv [6];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] e33_rd   [3] = '{16'h00AB, 16'h00CD, 16'h00AB};
  logic [23:0] e33_addr [3] = '{24'h120001, 24'h120002, 24'h120003};
  logic [23:0] e34_addr [4] = '{24'h120001, 24'h120002, 24'h120003, 24'h120001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [15:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick;
    bus.cfg_we    = 1'b0;
  endtask

  task automatic do_reset;
    rst               = 1'b1;
    bus.cfg_we        = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_wdata     = '0;
    bus.dma_req8      = 1'b0;
    bus.dma_req16     = 1'b0;
    bus.dma_writedata = '0;
    bus.mem_rdata     = '0;
    bus.mem_ready     = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic wait_ack(input string name, input int limit);
    int n = 0;
    while (!bus.dma_ack && n < limit) begin
      tick;
      n++;
    end
    chk({name, " ack seen"}, bus.dma_ack, 1);
  endtask

  task automatic wait_mem(input string name, input int limit);
    int n = 0;
    while (!(bus.mem_rd || bus.mem_wr) && n < limit) begin
      tick;
      n++;
    end
    chk({name, " memop seen"}, bus.mem_rd | bus.mem_wr, 1);
  endtask

  initial begin
    int acks, last;
    logic [2:0] b;
    logic [23:0] hold_addr;

    tv[0] = '{1'b0, 8'h12, 16'h0001, 16'h0000, 1'b0, 16'hABCD, 16'h0000, 24'h120001, 2'b10, 16'h00AB, 1'b1, 1'b1};
    tv[1] = '{1'b0, 8'h34, 16'h0010, 16'h0005, 1'b0, 16'h5AA5, 16'h0000, 24'h340010, 2'b01, 16'h00A5, 1'b0, 1'b0};
    tv[2] = '{1'b0, 8'h7F, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h12C3, 24'h7FFFFF, 2'b10, 16'hC3C3, 1'b1, 1'b1};
    tv[3] = '{1'b1, 8'h05, 16'h8000, 16'h0000, 1'b1, 16'h0000, 16'h1234, 24'h050000, 2'b11, 16'h1234, 1'b1, 1'b1};
    tv[4] = '{1'b1, 8'h0A, 16'h1234, 16'h0003, 1'b0, 16'hBEEF, 16'h0000, 24'h0A2468, 2'b11, 16'hBEEF, 1'b0, 1'b0};
    tv[5] = '{1'b1, 8'h0B, 16'hFFFF, 16'h0000, 1'b0, 16'h0F0F, 16'h0000, 24'h0BFFFE, 2'b11, 16'h0F0F, 1'b1, 1'b1};

    // Reset state, and a masked request must never be granted.
    do_reset;
    chk("rst ack", bus.dma_ack, 0);
    chk("rst rd/wr", {bus.mem_rd, bus.mem_wr}, 0);
    chk("rst tc", {bus.tc8, bus.tc16}, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst be/wdata", {bus.mem_be, bus.mem_wdata}, 0);
    chk("rst readdata", bus.dma_readdata, 0);
    chk("rst masks", {bus.mask8, bus.mask16}, 2'b11);
    bus.dma_req8  = 1'b1;
    bus.dma_req16 = 1'b1;
    acks = 0;
    for (int n = 0; n < 15; n++) begin
      if (bus.dma_ack) acks++;
      tick;
    end
    chk("masked no ack", acks, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset;
      b = tv[i].ch ? 3'd3 : 3'd0;
      cfg(b, tv[i].addr);
      cfg(b + 3'd1, tv[i].cnt);
      cfg(b + 3'd2, {7'b0, tv[i].dir, tv[i].page});
      bus.mem_rdata     = tv[i].rdata;
      bus.dma_writedata = tv[i].wdata;
      if (tv[i].ch) bus.dma_req16 = 1'b1;
      else          bus.dma_req8  = 1'b1;
      wait_mem($sformatf("v%0d", i), 20);
      chk($sformatf("v%0d rd/wr", i), {bus.mem_rd, bus.mem_wr}, tv[i].dir ? 2'b01 : 2'b10);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tv[i].e_addr);
      chk($sformatf("v%0d mem_be", i), bus.mem_be, tv[i].e_be);
      if (tv[i].dir) chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tv[i].e_data);
      wait_ack($sformatf("v%0d", i), 20);
      bus.dma_req8  = 1'b0;
      bus.dma_req16 = 1'b0;
      if (!tv[i].dir) chk($sformatf("v%0d readdata", i), bus.dma_readdata, tv[i].e_data);
      chk($sformatf("v%0d tc", i), tv[i].ch ? bus.tc16 : bus.tc8, tv[i].e_tc);
      tick;
      chk($sformatf("v%0d mask", i), tv[i].ch ? bus.mask16 : bus.mask8, tv[i].e_mask);
    end

    // Count 2 yields three transfers, tc on the third, then masked.
    do_reset;
    cfg(3'd0, 16'h0001);
    cfg(3'd1, 16'h0002);
    cfg(3'd2, 16'h0012);
    bus.mem_rdata = 16'hABCD;
    bus.dma_req8  = 1'b1;
    acks = 0;
    last = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.dma_ack) begin
        if (acks < 3) begin
          chk($sformatf("s33 rd%0d", acks), bus.dma_readdata, e33_rd[acks]);
          chk($sformatf("s33 addr%0d", acks), bus.mem_addr, e33_addr[acks]);
          chk($sformatf("s33 tc%0d", acks), bus.tc8, acks == 2);
          if (acks > 0) chk($sformatf("s33 spacing%0d", acks), cyc - last, 5);
        end
        last = cyc;
        acks++;
      end
      tick;
    end
    chk("s33 ack count", acks, 3);
    chk("s33 mask8", bus.mask8, 1);
    bus.dma_req8 = 1'b0;

    // Autoinit: reload after tc and keep going.
    do_reset;
    cfg(3'd0, 16'h0001);
    cfg(3'd1, 16'h0002);
    cfg(3'd2, 16'h0212);
    bus.mem_rdata = 16'hABCD;
    bus.dma_req8  = 1'b1;
    acks = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.dma_ack) begin
        if (acks < 4) begin
          chk($sformatf("s34 addr%0d", acks), bus.mem_addr, e34_addr[acks]);
          chk($sformatf("s34 tc%0d", acks), bus.tc8, acks == 2);
        end
        acks++;
        if (acks == 4) bus.dma_req8 = 1'b0;
      end
      tick;
    end
    chk("s34 ack count", acks, 4);
    chk("s34 mask8", bus.mask8, 0);

    // Simultaneous requests: ch8 first, ch16 one full transfer later.
    do_reset;
    cfg(3'd0, 16'h0040);
    cfg(3'd1, 16'h0000);
    cfg(3'd2, 16'h0012);
    cfg(3'd3, 16'h0100);
    cfg(3'd4, 16'h0000);
    cfg(3'd5, 16'h0005);
    bus.dma_req8  = 1'b1;
    bus.dma_req16 = 1'b1;
    acks = 0;
    last = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.dma_ack) begin
        if (acks == 0) begin
          chk("s36 first addr", bus.mem_addr, 24'h120040);
          bus.dma_req8 = 1'b0;
        end else if (acks == 1) begin
          chk("s36 second addr", bus.mem_addr, 24'h040200);
          chk("s36 spacing", cyc - last, 5);
          bus.dma_req16 = 1'b0;
        end
        last = cyc;
        acks++;
      end
      tick;
    end
    chk("s36 ack count", acks, 2);

    // Slow memory: mem_rd held 7 cycles, ack one cycle after ready.
    do_reset;
    cfg(3'd0, 16'h0100);
    cfg(3'd1, 16'h0000);
    cfg(3'd2, 16'h0012);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h7766;
    bus.dma_req8  = 1'b1;
    wait_mem("s37", 20);
    hold_addr = bus.mem_addr;
    chk("s37 addr", hold_addr, 24'h120100);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("s37 rd%0d", i), bus.mem_rd, 1);
      chk($sformatf("s37 addr%0d", i), bus.mem_addr, hold_addr);
      chk($sformatf("s37 noack%0d", i), bus.dma_ack, 0);
      if (i == 6) bus.mem_ready = 1'b1;
      tick;
    end
    chk("s37 ack", bus.dma_ack, 1);
    chk("s37 rd dropped", bus.mem_rd, 0);
    chk("s37 readdata", bus.dma_readdata, 16'h0066);
    bus.dma_req8 = 1'b0;
    tick;
    chk("s37 ack one cycle", bus.dma_ack, 0);

    // cfg write to page/mode in the tc ACK cycle beats the auto-mask.
    do_reset;
    cfg(3'd0, 16'h0001);
    cfg(3'd1, 16'h0000);
    cfg(3'd2, 16'h0012);
    bus.dma_req8 = 1'b1;
    wait_ack("s27", 20);
    bus.dma_req8 = 1'b0;
    chk("s27 tc8", bus.tc8, 1);
    cfg(3'd2, 16'h0012);
    chk("s27 mask8 kept", bus.mask8, 0);

    // Reset during MEM abandons the transfer.
    do_reset;
    cfg(3'd0, 16'h0003);
    cfg(3'd1, 16'h0004);
    cfg(3'd2, 16'h0012);
    bus.mem_ready = 1'b0;
    bus.dma_req8  = 1'b1;
    wait_mem("s38", 20);
    chk("s38 pre addr", bus.mem_addr, 24'h120003);
    tick;
    rst = 1'b1;
    #1;
    chk("s38 ack", bus.dma_ack, 0);
    chk("s38 rd/wr", {bus.mem_rd, bus.mem_wr}, 0);
    chk("s38 tc", {bus.tc8, bus.tc16}, 0);
    chk("s38 mem_addr", bus.mem_addr, 0);
    chk("s38 be/wdata", {bus.mem_be, bus.mem_wdata}, 0);
    chk("s38 readdata", bus.dma_readdata, 0);
    chk("s38 masks", {bus.mask8, bus.mask16}, 2'b11);
    bus.mem_ready = 1'b1;
    tick;
    rst  = 1'b0;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.dma_ack || bus.tc8) acks++;
      tick;
    end
    chk("s38 no ack after", acks, 0);
    bus.dma_req8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
